i2c_codec_responder: RTL and testbench



---
 rtl/i2c_codec_responder.sv | 169 ++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder modelling the audio codec control port: ACKs
// 3-byte writes and shadows them into a 16-entry register file.
module i2c_codec_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter logic [6:0] RESET_REG  = 7'h0F
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oWR_STB,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic       oBUSY
);

  localparam int unsigned REGS = 16;

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE
  } state_t;

  state_t     state, state_nx;
  logic [2:0] scl_sr, sda_sr;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] hi_byte, hi_byte_nx;
  logic       ack_phase, ack_phase_nx;
  logic       ack_ok, ack_ok_nx;
  logic       sda_low, sda_low_nx;
  logic       busy_nx;
  logic       commit_c;
  logic [7:0] byte_c;
  logic [8:0] regfile [REGS];

  // Idle bus reads high, so reset the synchronizers to 1 to avoid a false START.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], I2C_SCLK};
      sda_sr <= {sda_sr[1:0], I2C_SDAT};
    end
  end

  wire scl_s = scl_sr[1];
  wire scl_d = scl_sr[2];
  wire sda_s = sda_sr[1];
  wire sda_d = sda_sr[2];
  wire scl_rise = scl_s & ~scl_d;
  wire scl_fall = ~scl_s & scl_d;
  wire start_ev = scl_s & scl_d & sda_d & ~sda_s;
  wire stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_c   = {shift[6:0], sda_s};
  assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;
  assign oRD_DATA = regfile[iRD_ADDR];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      hi_byte   <= 8'd0;
      ack_phase <= 1'b0;
      ack_ok    <= 1'b0;
      sda_low   <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      hi_byte   <= hi_byte_nx;
      ack_phase <= ack_phase_nx;
      ack_ok    <= ack_ok_nx;
      sda_low   <= sda_low_nx;
      oBUSY     <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    hi_byte_nx   = hi_byte;
    ack_phase_nx = ack_phase;
    ack_ok_nx    = ack_ok;
    sda_low_nx   = sda_low;
    busy_nx      = oBUSY;
    commit_c     = 1'b0;
    if (start_ev) begin
      state_nx     = ADDR;
      bit_cnt_nx   = 3'd0;
      ack_phase_nx = 1'b0;
      sda_low_nx   = 1'b0;
      busy_nx      = 1'b1;
    end else if (stop_ev) begin
      state_nx     = IDLE;
      ack_phase_nx = 1'b0;
      sda_low_nx   = 1'b0;
      busy_nx      = 1'b0;
    end else begin
      case (state)
        ADDR, HI, LO: begin
          if (scl_rise) begin
            shift_nx   = byte_c;
            bit_cnt_nx = 3'(bit_cnt + 3'd1);
            if (bit_cnt == 3'd7) begin
              ack_phase_nx = 1'b0;
              if (state == ADDR) begin
                state_nx  = ACK_A;
                ack_ok_nx = (byte_c == {SLAVE_ADDR, 1'b0});
              end else if (state == HI) begin
                state_nx   = ACK_H;
                hi_byte_nx = byte_c;
              end else begin
                state_nx = ACK_L;
                commit_c = 1'b1;
              end
            end
          end
        end
        // First SCL fall after the byte starts the 9th clock, the second ends it.
        ACK_A, ACK_H, ACK_L: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase_nx = 1'b1;
              sda_low_nx   = (state == ACK_A) ? ack_ok : 1'b1;
            end else begin
              ack_phase_nx = 1'b0;
              sda_low_nx   = 1'b0;
              bit_cnt_nx   = 3'd0;
              case (state)
                ACK_A:   state_nx = ack_ok ? HI : IGNORE;
                ACK_H:   state_nx = LO;
                default: state_nx = IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oWR_STB   <= 1'b0;
      oREG_ADDR <= 7'd0;
      oREG_DATA <= 9'd0;
      for (int i = 0; i < REGS; i++) regfile[i] <= 9'd0;
    end else begin
      oWR_STB <= commit_c;
      if (commit_c) begin
        oREG_ADDR <= hi_byte[7:1];
        oREG_DATA <= {hi_byte[0], byte_c};
        if (hi_byte[7:1] == RESET_REG) begin
          for (int i = 0; i < REGS; i++) regfile[i] <= 9'd0;
        end else if (hi_byte[7:5] == 3'd0) begin
          regfile[hi_byte[4:1]] <= {hi_byte[0], byte_c};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bit-banged I2C initiator with
// hand-computed expectations checked by immediate assertions.
module tb_i2c_codec_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       master_low;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_stb;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  wire        sda_bus;

  int total = 0;
  int bad = 0;
  int stb_cnt = 0;
  int rogue_low = 0;
  logic a0, a1, a2, a3;

  assign sda_bus = master_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_codec_responder dut (
    .iCLK      (clk),
    .iRST      (rst),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda_bus),
    .iRD_ADDR  (rd_addr),
    .oRD_DATA  (rd_data),
    .oWR_STB   (wr_stb),
    .oREG_ADDR (reg_addr),
    .oREG_DATA (reg_data),
    .oBUSY     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) stb_cnt++;
    if (sda_bus === 1'b0 && !master_low) rogue_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    master_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    master_low = 1'b1; wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic i2c_stop();
    master_low = 1'b1; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    master_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      master_low = ~b[7-i]; wait_clk(Q);
      scl = 1'b1;           wait_clk(2*Q);
      scl = 1'b0;           wait_clk(Q);
    end
  endtask

  task automatic get_ack(output logic a);
    master_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    a = sda_bus;       wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    get_ack(a);
  endtask

  task automatic rd(input logic [3:0] a, output logic [8:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  initial begin
    logic [8:0] d;
    logic [8:0] orall;
    rst = 1'b1; scl = 1'b1; master_low = 1'b0; rd_addr = 4'd0;
    wait_clk(4);
    chk("rst_sda", 32'(sda_bus), 32'h1);
    chk("rst_stb", 32'(wr_stb), 32'h0);
    chk("rst_addr", 32'(reg_addr), 32'h0);
    chk("rst_data", 32'(reg_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clk(4);

    // 34/08/F2 -> reg 4 = 0x0F2
    i2c_start();
    chk("t1_busy", 32'(busy), 32'h1);
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'hF2, a2);
    i2c_stop();
    chk("t1_acks", 32'({a0, a1, a2}), 32'h0);
    chk("t1_stb", 32'(stb_cnt), 32'd1);
    chk("t1_addr", 32'(reg_addr), 32'h04);
    chk("t1_data", 32'(reg_data), 32'h0F2);
    rd(4'd4, d); chk("t1_rf4", 32'(d), 32'h0F2);
    chk("t1_idle", 32'(busy), 32'h0);

    // wrong device address 0x36
    rogue_low = 0;
    i2c_start();
    send_byte(8'h36, a0); send_byte(8'h08, a1); send_byte(8'h55, a2);
    chk("t2_nacks", 32'({a0, a1, a2}), 32'h7);
    chk("t2_busy", 32'(busy), 32'h1);
    i2c_stop();
    chk("t2_nodrive", 32'(rogue_low), 32'd0);
    chk("t2_stb", 32'(stb_cnt), 32'd1);
    chk("t2_idle", 32'(busy), 32'h0);

    // read request 0x35
    i2c_start();
    send_byte(8'h35, a0);
    i2c_stop();
    chk("t3_nack", 32'(a0), 32'h1);
    chk("t3_stb", 32'(stb_cnt), 32'd1);
    rd(4'd4, d); chk("t3_rf4", 32'(d), 32'h0F2);

    // 34/02/1A then reset-register write 34/1E/00
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h02, a1); send_byte(8'h1A, a2);
    i2c_stop();
    rd(4'd1, d); chk("t4_rf1", 32'(d), 32'h01A);
    chk("t4_stb1", 32'(stb_cnt), 32'd2);
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    i2c_stop();
    chk("t4_stb2", 32'(stb_cnt), 32'd3);
    chk("t4_addr", 32'(reg_addr), 32'h0F);
    orall = 9'd0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      orall = orall | d;
    end
    chk("t4_cleared", 32'(orall), 32'h0);

    // 34/12/01 plus a 4th byte that must be NACKed
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h12, a1); send_byte(8'h01, a2); send_byte(8'hAA, a3);
    i2c_stop();
    chk("t5_acks", 32'({a0, a1, a2, a3}), 32'h1);
    chk("t5_stb", 32'(stb_cnt), 32'd4);
    rd(4'd9, d); chk("t5_rf9", 32'(d), 32'h001);

    // repeated START after 4 bits of the HI byte, then 34/10/02
    i2c_start();
    send_byte(8'h34, a0);
    send_bits(8'hF0, 4);
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h10, a1); send_byte(8'h02, a2);
    i2c_stop();
    chk("t6_acks", 32'({a0, a1, a2}), 32'h0);
    chk("t6_stb", 32'(stb_cnt), 32'd5);
    chk("t6_addr", 32'(reg_addr), 32'h08);
    rd(4'd8, d); chk("t6_rf8", 32'(d), 32'h002);
    rd(4'd9, d); chk("t6_rf9", 32'(d), 32'h001);

    // reset while the address ACK is being driven
    i2c_start();
    send_bits(8'h34, 8);
    master_low = 1'b0;
    #1;
    chk("t7_acking", 32'(sda_bus), 32'h0);
    rst = 1'b1;
    #1;
    chk("t7_release", 32'(sda_bus), 32'h1);
    chk("t7_addr", 32'(reg_addr), 32'h0);
    rd(4'd8, d); chk("t7_rf8", 32'(d), 32'h0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    i2c_stop();
    chk("t7_nostb", 32'(stb_cnt), 32'd5);
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h0C, a1); send_byte(8'h00, a2);
    i2c_stop();
    chk("t7_acks", 32'({a0, a1, a2}), 32'h0);
    chk("t7_stb", 32'(stb_cnt), 32'd6);
    chk("t7_addr2", 32'(reg_addr), 32'h06);
    rd(4'd6, d); chk("t7_rf6", 32'(d), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
